// File: rtl/pcpi_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pcpi_issue_ctrl
// Stand-alone PCPI initiator: issues one request bundle, tracks wait/timeout,
// and returns the result with a status code and a saturating latency.
// Rev    : 1.0  initial release
// ============================================================================
module pcpi_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ENABLE_RS3     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_rs3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        rsp_wr,
    output logic [1:0]  rsp_status,
    output logic [7:0]  rsp_latency,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    output logic [31:0] pcpi_rs3,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        proto_err
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam logic [1:0] c_ST_OK    = 2'b00;
    localparam logic [1:0] c_ST_TMO   = 2'b01;
    localparam logic [1:0] c_ST_PROTO = 2'b10;
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [7:0]  lat_q, lat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  status_q, status_d;
    logic        proto_q, proto_d;
    logic [31:0] insn_q, rs1_q, rs2_q;
    logic        w_accept;

    assign w_accept = req_valid && (state_q == c_IDLE);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d      = state_q;
        pcpi_valid_d = pcpi_valid_q;
        lat_d        = lat_q;
        tmo_d        = tmo_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        status_d     = status_q;
        // Any coprocessor handshake while no instruction is offered is a violation
        proto_d      = proto_q | (~pcpi_valid_q & (pcpi_ready | pcpi_wait | pcpi_wr));
        case (state_q)
            c_IDLE: begin
                if (req_valid) begin
                    state_d      = c_ISSUE;
                    pcpi_valid_d = 1'b1;
                    lat_d        = 8'd0;
                    tmo_d        = 8'd0;
                end
            end
            c_ISSUE: begin
                lat_d = (lat_q == 8'hFF) ? 8'hFF : lat_q + 8'd1;
                if (pcpi_ready) begin
                    rd_d         = pcpi_rd;
                    wr_d         = pcpi_wr;
                    status_d     = c_ST_OK;
                    pcpi_valid_d = 1'b0;
                    state_d      = c_RESP;
                end else if (pcpi_wr) begin
                    rd_d         = 32'd0;
                    wr_d         = 1'b0;
                    status_d     = c_ST_PROTO;
                    proto_d      = 1'b1;
                    pcpi_valid_d = 1'b0;
                    state_d      = c_RESP;
                end else if (pcpi_wait) begin
                    tmo_d = 8'd0;
                end else if (tmo_q == c_TMO_LAST) begin
                    rd_d         = 32'd0;
                    wr_d         = 1'b0;
                    status_d     = c_ST_TMO;
                    pcpi_valid_d = 1'b0;
                    state_d      = c_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == c_IDLE);
        rsp_valid = (state_q == c_RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pcpi_valid_q <= 1'b0;
            lat_q        <= 8'd0;
            tmo_q        <= 8'd0;
            rd_q         <= 32'd0;
            wr_q         <= 1'b0;
            status_q     <= c_ST_OK;
            proto_q      <= 1'b0;
        end else begin
            pcpi_valid_q <= pcpi_valid_d;
            lat_q        <= lat_d;
            tmo_q        <= tmo_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            status_q     <= status_d;
            proto_q      <= proto_d;
        end
    end

    // Operands load only on acceptance, so they stay put through ISSUE and after
    always_ff @(posedge clock) begin
        if (reset) begin
            insn_q <= 32'd0;
            rs1_q  <= 32'd0;
            rs2_q  <= 32'd0;
        end else if (w_accept) begin
            insn_q <= req_insn;
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
        end
    end

    generate
        if (ENABLE_RS3) begin : g_rs3_on
            logic [31:0] rs3_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    rs3_q <= 32'd0;
                end else if (w_accept) begin
                    rs3_q <= req_rs3;
                end
            end
            assign pcpi_rs3 = rs3_q;
        end else begin : g_rs3_off
            assign pcpi_rs3 = 32'd0;
        end
    endgenerate

    assign pcpi_valid  = pcpi_valid_q;
    assign pcpi_insn   = insn_q;
    assign pcpi_rs1    = rs1_q;
    assign pcpi_rs2    = rs2_q;
    assign rsp_rd      = rd_q;
    assign rsp_wr      = wr_q;
    assign rsp_status  = status_q;
    assign rsp_latency = lat_q;
    assign proto_err   = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_pcpi_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pcpi_issue_ctrl
// Randomized and directed bench for pcpi_issue_ctrl with a script-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pcpi_issue_ctrl;

    localparam int T    = 16;
    localparam int MAXS = 320;

    logic        clock = 1'b0;
    logic        reset, rst4;
    logic        req_valid, req_valid4, req_ready, req_ready4;
    logic [31:0] req_insn, req_rs1, req_rs2, req_rs3;
    logic        rsp_valid, rsp_valid4, rsp_ready, rsp_ready4;
    logic [31:0] rsp_rd, rsp_rd4;
    logic        rsp_wr, rsp_wr4;
    logic [1:0]  rsp_status, rsp_status4;
    logic [7:0]  rsp_latency, rsp_latency4;
    logic        pcpi_valid, pcpi_valid4;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3;
    logic [31:0] pcpi_insn4, pcpi_rs1_4, pcpi_rs2_4, pcpi_rs3_4;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        proto_err, proto_err4;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_proto = 1'b0;

    // Coprocessor behaviour script: one entry per pcpi_valid-high cycle
    bit          sw  [MAXS];
    bit          sr  [MAXS];
    bit          swr [MAXS];
    logic [31:0] srd [MAXS];

    always #5 clock = ~clock;

    pcpi_issue_ctrl #(.TIMEOUT_CYCLES(T), .ENABLE_RS3(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_wr(rsp_wr),
        .rsp_status(rsp_status), .rsp_latency(rsp_latency),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .proto_err(proto_err)
    );

    pcpi_issue_ctrl #(.TIMEOUT_CYCLES(4), .ENABLE_RS3(1'b0)) dut4 (
        .clock(clock), .reset(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_rd(rsp_rd4), .rsp_wr(rsp_wr4),
        .rsp_status(rsp_status4), .rsp_latency(rsp_latency4),
        .pcpi_valid(pcpi_valid4), .pcpi_insn(pcpi_insn4), .pcpi_rs1(pcpi_rs1_4),
        .pcpi_rs2(pcpi_rs2_4), .pcpi_rs3(pcpi_rs3_4),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .proto_err(proto_err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_script();
        for (int i = 0; i < MAXS; i++) begin
            sw[i] = 1'b0; sr[i] = 1'b0; swr[i] = 1'b0; srd[i] = $urandom;
        end
    endtask

    // Outcome from the rules: first ready wins, else wr is a protocol error,
    // else T consecutive silent cycles is a timeout.
    task automatic model(input int len, output int k, output logic [1:0] st,
                         output logic [31:0] rd, output bit wr);
        int idle = 0;
        k = len; st = 2'b01; rd = 32'd0; wr = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (sr[i]) begin
                k = i + 1; st = 2'b00; rd = srd[i]; wr = swr[i]; return;
            end else if (swr[i]) begin
                k = i + 1; st = 2'b10; return;
            end else if (sw[i]) begin
                idle = 0;
            end else begin
                idle++;
                if (idle == T) begin
                    k = i + 1; st = 2'b01; return;
                end
            end
        end
    endtask

    task automatic do_txn(input logic [31:0] insn, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] rs3,
                          input int len, input int rsp_delay, input bit hold_req);
        int k; logic [1:0] st; logic [31:0] erd; bit ewr; int elat;
        model(len, k, st, erd, ewr);
        elat = (k > 255) ? 255 : k;
        if (st == 2'b10) exp_proto = 1'b1;
        @(negedge clock);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2; req_rs3 = rs3;
        @(negedge clock);
        req_valid = 1'b0; req_insn = $urandom; req_rs1 = $urandom;
        req_rs2 = $urandom; req_rs3 = $urandom;
        for (int i = 0; i < k; i++) begin
            if (i > 0) @(negedge clock);
            chk("pcpi_valid_hi", pcpi_valid, 1);
            chk("req_ready_busy", req_ready, 0);
            chk("pcpi_insn", pcpi_insn, insn);
            if (i == 0) begin
                chk("pcpi_rs1", pcpi_rs1, rs1);
                chk("pcpi_rs2", pcpi_rs2, rs2);
                chk("pcpi_rs3", pcpi_rs3, rs3);
            end
            pcpi_wait = sw[i]; pcpi_ready = sr[i]; pcpi_wr = swr[i]; pcpi_rd = srd[i];
        end
        @(negedge clock);
        pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = $urandom;
        chk("pcpi_valid_lo", pcpi_valid, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rd", rsp_rd, erd);
        chk("rsp_wr", rsp_wr, ewr);
        chk("rsp_status", rsp_status, st);
        chk("rsp_latency", rsp_latency, elat);
        chk("proto_err", proto_err, exp_proto);
        chk("pcpi_insn_kept", pcpi_insn, insn);
        for (int d = 0; d < rsp_delay; d++) begin
            req_valid = hold_req; req_insn = $urandom; req_rs1 = $urandom;
            @(negedge clock);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rd", rsp_rd, erd);
            chk("hold_status", rsp_status, st);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_pcpi_valid", pcpi_valid, 0);
            chk("hold_pcpi_insn", pcpi_insn, insn);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_pcpi_valid", pcpi_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_proto = 1'b0;
        chk("reset_proto", proto_err, 0);
    endtask

    task automatic rand_txn();
        int mode, len, r;
        clear_script();
        mode = $urandom_range(0, 9);
        if (mode == 0) begin
            len = 1; sr[0] = 1'b1; swr[0] = 1'($urandom);
        end else if (mode == 1) begin
            len = T + 2;
        end else if (mode == 2) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len - 1; i++) sw[i] = 1'($urandom);
            swr[len-1] = 1'b1;
        end else begin
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 8) begin
                    sr[i] = 1'b1; swr[i] = 1'($urandom);
                end else if (r < 11) begin
                    swr[i] = 1'b1;
                end else if (r < 60) begin
                    sw[i] = 1'b1;
                end
            end
            sr[len-1] = 1'b1;
        end
        do_txn($urandom, $urandom, $urandom, $urandom, len, $urandom_range(0, 3), 1'($urandom));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rst4 = 1'b1;
        req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
        req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
        pcpi_wr = 1'b0; pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_rd = '0;
        repeat (2) @(negedge clock);
        chk("rst_pcpi_valid", pcpi_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_rsp_wr", rsp_wr, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_latency", rsp_latency, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_pcpi_insn", pcpi_insn, 0);
        chk("rst_pcpi_rs3", pcpi_rs3, 0);
        reset = 1'b0;

        clear_script(); sr[0] = 1'b1; swr[0] = 1'b1; srd[0] = 32'h4;
        do_txn(32'h6005_1513, 32'h0000_00F0, 32'h0, 32'h0, 1, 0, 1'b0);

        clear_script();
        for (int i = 0; i < 5; i++) sw[i] = 1'b1;
        sr[5] = 1'b1; srd[5] = 32'hDEAD_BEEF;
        do_txn(32'h1111_0001, 32'h1, 32'h2, 32'h3, 6, 1, 1'b0);

        clear_script();
        for (int i = 0; i < 40; i++) sw[i] = 1'b1;
        sr[40] = 1'b1; srd[40] = 32'hDEAD_BEEF;
        do_txn(32'h1111_0002, 32'h4, 32'h5, 32'h6, 41, 0, 1'b0);

        clear_script();
        do_txn(32'h2222_0000, 32'h7, 32'h8, 32'h9, T + 4, 0, 1'b0);

        clear_script();
        for (int i = 0; i < T - 1; i++) sw[i] = 1'b0;
        sw[T-1] = 1'b1;
        sr[2*T-1] = 1'b1;
        do_txn(32'h2222_0001, 32'hA, 32'hB, 32'hC, 2 * T, 0, 1'b0);

        clear_script(); sr[2] = 1'b1; srd[2] = 32'hCAFE_F00D;
        do_txn(32'h3333_0000, 32'hD, 32'hE, 32'hF, 3, 10, 1'b1);

        clear_script(); sw[0] = 1'b1; swr[2] = 1'b1;
        do_txn(32'h4444_0000, 32'h10, 32'h11, 32'h12, 3, 0, 1'b0);
        clear_script(); sr[0] = 1'b1;
        do_txn(32'h4444_0001, 32'h13, 32'h14, 32'h15, 1, 0, 1'b0);

        clear_script();
        for (int i = 0; i < 299; i++) sw[i] = 1'b1;
        sr[299] = 1'b1;
        do_txn(32'h5555_0000, 32'h16, 32'h17, 32'h18, 300, 0, 1'b0);
        do_reset();

        @(negedge clock);
        pcpi_wait = 1'b1;
        @(negedge clock);
        pcpi_wait = 1'b0;
        chk("stray_wait_proto", proto_err, 1);
        do_reset();

        @(negedge clock);
        req_valid = 1'b1; req_insn = 32'h6666_0000;
        @(negedge clock);
        req_valid = 1'b0; pcpi_wait = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; pcpi_wait = 1'b0;
        chk("abort_pcpi_valid", pcpi_valid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_proto", proto_err, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("abort_no_rsp", rsp_valid, 0);
        end

        @(negedge clock);
        rst4 = 1'b0; req_valid4 = 1'b1;
        req_insn = 32'h7777_0000; req_rs1 = 32'h21; req_rs2 = 32'h22; req_rs3 = 32'h23;
        @(negedge clock);
        req_valid4 = 1'b0;
        chk("t4_rs3_zero", pcpi_rs3_4, 0);
        chk("t4_insn", pcpi_insn4, 32'h7777_0000);
        chk("t4_rs1", pcpi_rs1_4, 32'h21);
        chk("t4_rs2", pcpi_rs2_4, 32'h22);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            chk("t4_pcpi_valid", pcpi_valid4, 1);
        end
        @(negedge clock);
        chk("t4_pcpi_valid_lo", pcpi_valid4, 0);
        chk("t4_rsp_valid", rsp_valid4, 1);
        chk("t4_status", rsp_status4, 2'b01);
        chk("t4_latency", rsp_latency4, 4);
        chk("t4_rd", rsp_rd4, 0);
        chk("t4_wr", rsp_wr4, 0);
        chk("t4_proto", proto_err4, 0);
        rsp_ready4 = 1'b1;
        @(negedge clock);
        rsp_ready4 = 1'b0;
        chk("t4_req_ready", req_ready4, 1);
        rst4 = 1'b1;

        for (int n = 0; n < 60; n++) rand_txn();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
